// File: rtl/ff_share_pkg.sv
// Shared types and helpers for the ff_share_arb round-robin register sharer.
// Holds the arbiter state encoding, default widths and the rotating first-set search.
package ff_share_pkg;

  localparam int LPM_WIDTH_DEF = 8;
  localparam int NREQ_DEF      = 4;
  localparam int TAGW_DEF      = 2;
  localparam int NREQ_MAX      = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... wrapping at nreq.
  // Scanned from the far end back towards ptr so the nearest hit is the one kept.
  function automatic logic [3:0] rr_first_set(input logic [7:0] req,
                                              input logic [2:0] ptr,
                                              input int         nreq);
    logic [3:0] res;
    int         j;
    res = 4'b0000;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= nreq) j = j - nreq;
      if ((k < nreq) && req[j[2:0]]) res = {1'b1, j[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ff_share_arb_rr_pick.sv
// Combinational round-robin pick: one-hot grant plus binary index, starting at ptr_i.
// Zero latency; en_i low forces no grant.
module rr_pick
  import ff_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TAGW-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [TAGW-1:0] idx_o,
  output logic            any_o
);

  logic [3:0] pick;

  always_comb begin
    pick  = rr_first_set(8'(req_i), 3'(ptr_i), NREQ);
    any_o = en_i & pick[3];
    idx_o = TAGW'(pick[2:0]);
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ff_share_arb.sv
// Round-robin sharer of one lpm_width register among NREQ producers; word lands on q one cycle after grant.
// Grants only while q is empty or draining; FF_SHARE_ARB_LOCK_EN adds a per-requester lock input.
module ff_share_arb
  import ff_share_pkg::*;
#(
  parameter int lpm_width = LPM_WIDTH_DEF,
  parameter int NREQ      = NREQ_DEF,
  parameter int TAGW      = TAGW_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*lpm_width-1:0] data,
`ifdef FF_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]           lock,
`endif
  output logic [NREQ-1:0]           gnt,
  output logic [lpm_width-1:0]      q,
  output logic [TAGW-1:0]           q_tag,
  output logic                      q_valid,
  input  logic                      q_ready
);

  logic [lpm_width-1:0] q_q, q_d;
  logic [TAGW-1:0]      tag_q, tag_d;
  logic                 vld_q, vld_d;
  logic [TAGW-1:0]      ptr_q;
  logic [NREQ-1:0]      req_eff;
  logic [TAGW-1:0]      gnt_idx, ptr_inc;
  logic                 gnt_any, accept;

`ifdef FF_SHARE_ARB_LOCK_EN
  arb_state_e           state_q;
  logic [TAGW-1:0]      owner_q, owner_inc;

  // While locked only the owner's request is visible to the picker.
  always_comb begin
    req_eff = req;
    if (state_q == LOCKED) begin
      req_eff          = '0;
      req_eff[owner_q] = req[owner_q];
    end
  end

  assign owner_inc = (owner_q == TAGW'(NREQ - 1)) ? '0 : owner_q + TAGW'(1);
`else
  assign req_eff = req;
`endif

  assign accept  = !vld_q || q_ready;
  assign ptr_inc = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);

  rr_pick #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_pick (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .en_i  (accept && reset),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Load mux in front of the shared register; drain-only cycles keep the old word.
  always_comb begin
    q_d   = q_q;
    tag_d = tag_q;
    vld_d = vld_q;
    if (gnt_any) begin
      q_d   = data[gnt_idx*lpm_width +: lpm_width];
      tag_d = gnt_idx;
      vld_d = 1'b1;
    end else if (q_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_q   <= '0;
      tag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tag_q <= tag_d;
      vld_q <= vld_d;
    end
  end

`ifdef FF_SHARE_ARB_LOCK_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ARB;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (gnt_any) begin
            if (lock[gnt_idx]) begin
              state_q <= LOCKED;
              owner_q <= gnt_idx;
            end else begin
              ptr_q <= ptr_inc;
            end
          end
        end
        LOCKED: begin
          if (!req[owner_q] || (gnt_any && !lock[owner_q])) begin
            state_q <= ARB;
            ptr_q   <= owner_inc;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end
`else
  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else if (gnt_any) ptr_q <= ptr_inc;
  end
`endif

  assign q       = q_q;
  assign q_tag   = tag_q;
  assign q_valid = vld_q;

endmodule

// File: tb/tb_ff_share_arb.sv
// Directed bench for ff_share_arb with a grant model and an output scoreboard.
module tb_ff_share_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_tag;
  logic        q_valid;
  logic        q_ready;
`ifdef FF_SHARE_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int checks = 0;
  int errors = 0;

  int         m_ptr;
  bit         m_vld;
  logic [9:0] sb[$];
  logic [7:0] obs_q;
  logic [1:0] obs_tag;

  always #5 clock = ~clock;

  ff_share_arb #(.lpm_width(8), .NREQ(4), .TAGW(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .data    (data),
`ifdef FF_SHARE_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_tag   (q_tag),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_vld = 1'b0;
    sb.delete();
  endtask

  // One cycle: drive at negedge, check grant, then check q after the edge.
  task automatic cycle(input logic [3:0] r, input logic rdy, input string nm);
    logic [3:0] eg;
    logic [9:0] e;
    int         idx;
    bit         acc;
    req     = r;
    q_ready = rdy;
    #1;
    acc = !m_vld || rdy;
    eg  = 4'b0;
    idx = -1;
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (idx < 0 && r[j]) idx = j;
      end
    end
    if (idx >= 0) eg[idx] = 1'b1;
    chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
    if (idx >= 0) begin
      sb.push_back({data[idx*8 +: 8], 2'(idx)});
      m_ptr = (idx + 1) % 4;
      m_vld = 1'b1;
    end else if (rdy) begin
      m_vld = 1'b0;
    end
    @(posedge clock);
    #1;
    chk({nm, ".vld"}, 32'(q_valid), 32'(m_vld));
    if (idx >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, ".q"},   32'(q),     32'(e[9:2]));
      chk({nm, ".tag"}, 32'(q_tag), 32'(e[1:0]));
    end
    obs_q   = q;
    obs_tag = q_tag;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] exp_q[5];
    logic [1:0] exp_t[5];
    exp_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    exp_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    data    = 32'h4332_2110;
    req     = 4'b1111;
    q_ready = 1'b0;
    reset   = 1'b0;
`ifdef FF_SHARE_ARB_LOCK_EN
    lock    = 4'b0000;
`endif
    model_reset();

    // Reset held three edges with all requests high
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst.gnt", 32'(gnt), 32'h0);
      chk("rst.q",   32'(q),   32'h0);
      chk("rst.vld", 32'(q_valid), 32'h0);
      chk("rst.tag", 32'(q_tag),   32'h0);
    end
    reset = 1'b1;
    #1;
    chk("rst.first_gnt", 32'(gnt), 32'h1);

    // Fair rotation
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, "rot");
      chk("rot.seq_q",   32'(obs_q),   32'(exp_q[i]));
      chk("rot.seq_tag", 32'(obs_tag), 32'(exp_t[i]));
    end

    // Bring ptr to 3, then skip and wrap with req=0101
    cycle(4'b1111, 1'b1, "pre");
    cycle(4'b1111, 1'b1, "pre");
    cycle(4'b0101, 1'b1, "wrap");
    chk("wrap.t0", 32'(obs_tag), 32'd0);
    cycle(4'b0101, 1'b1, "wrap");
    chk("wrap.t1", 32'(obs_tag), 32'd2);
    cycle(4'b0101, 1'b1, "wrap");
    chk("wrap.t2", 32'(obs_tag), 32'd0);

    // Backpressure: q holds word 0, requester 1 waits
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0010, 1'b0, "stall");
      chk("stall.q",   32'(obs_q),   32'h10);
      chk("stall.vld", 32'(q_valid), 32'h1);
    end
    cycle(4'b0010, 1'b1, "drainload");
    chk("drainload.q",   32'(obs_q),   32'h21);
    chk("drainload.tag", 32'(obs_tag), 32'd1);

    // Idle drain then confirm ptr stayed at 2
    cycle(4'b0000, 1'b1, "idle");
    chk("idle.q_hold", 32'(obs_q), 32'h21);
    cycle(4'b0000, 1'b1, "idle");
    cycle(4'b1111, 1'b1, "after_idle");
    chk("after_idle.tag", 32'(obs_tag), 32'd2);

    // Reset mid-stream discards the in-flight word
    cycle(4'b1111, 1'b0, "pre_rst");
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst.vld", 32'(q_valid), 32'h0);
    chk("midrst.q",   32'(q),       32'h0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    cycle(4'b1111, 1'b1, "post_rst");
    chk("post_rst.tag", 32'(obs_tag), 32'd0);

`ifdef FF_SHARE_ARB_LOCK_EN
    // Lock: requester 0 holds the register for three grants, then releases
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset   = 1'b1;
    req     = 4'b0011;
    q_ready = 1'b1;
    lock    = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock.gnt", 32'(gnt), 32'h1);
      @(posedge clock);
      #1;
      chk("lock.tag", 32'(q_tag), 32'd0);
      @(negedge clock);
    end
    lock = 4'b0000;
    #1;
    chk("unlock.gnt0", 32'(gnt), 32'h1);
    @(posedge clock);
    #1;
    chk("unlock.tag0", 32'(q_tag), 32'd0);
    @(negedge clock);
    #1;
    chk("unlock.gnt1", 32'(gnt), 32'h2);
    @(posedge clock);
    #1;
    chk("unlock.tag1", 32'(q_tag), 32'd1);
    @(negedge clock);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_share_arb.md
Name: ff_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one N-bit pipeline register among NREQ requesters.
- Each cycle it picks at most one requesting source and loads that source's word into the shared register. It then presents the word downstream with a valid/ready handshake and the source index.
- Sits in front of shared DSP datapath stages (MAC, CORDIC input, FIR tap bus) fed by several producers.

Parameters:
- lpm_width, 8, data word width in bits.
- NREQ, 4, number of requesters (legal range 2..8).
- TAGW, 2, width of the source index; must equal ceil(log2(NREQ)).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- req  in  NREQ  per-requester request; bit i is high while requester i holds a valid word.
- data  in  NREQ*lpm_width  requester words; slice i is bits [i*lpm_width +: lpm_width].
- gnt  out  NREQ  one-hot grant, combinational. req[i]&gnt[i] means word i is transferred at this edge.
- q  out  lpm_width  shared register contents.
- q_tag  out  TAGW  index of the requester whose word is in q.
- q_valid  out  1  q holds a word not yet consumed.
- q_ready  in  1  downstream accepts q when q_valid&q_ready.

Behaviour:
- Reset (reset==0 at an edge): q=0, q_tag=0, q_valid=0, ptr=0, FSM=ARB. While reset==0, gnt is forced to 0.
- accept = !q_valid | q_ready. The register may load whenever it is empty or being drained in the same cycle.
- Grant rule:
  - If accept=1 and any req is high, gnt selects the first set req at index ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - Otherwise gnt=0.
- On a grant edge:
  - q <= data slice of the granted index, q_tag <= that index, q_valid <= 1.
  - ptr <= granted index+1. Index NREQ-1 wraps ptr to 0.
- No grant and q_ready=1: q_valid <= 0. q and q_tag hold their last values.
- Stall (q_valid=1, q_ready=0): gnt=0, and q, q_tag, q_valid, ptr all hold.
- Simultaneous drain and load: the old word is consumed and the new word is loaded at the same edge. Sustained throughput is 1 word per cycle.
- Latency: a request granted in cycle n appears on q/q_valid in cycle n+1.
- No request pending: ptr does not move.
- Requesters may drop req at any time. An ungranted requester loses nothing.
- Reset asserted mid-stream: any in-flight word is discarded and all state returns to reset values on the next edge.
- FSM states:
  - ARB: normal round-robin operation.
  - LOCKED: present only with the optional feature.

Optional Feature:
- Macro FF_SHARE_ARB_LOCK_EN.
- Defined:
  - Adds input lock [NREQ].
  - If granted requester i has lock[i]=1 at the grant edge, FSM goes to LOCKED with owner=i, and ptr is not advanced.
  - In LOCKED, only requester owner can be granted; all other requests are ignored.
  - LOCKED returns to ARB at the first owner grant edge with lock[owner]=0, or the first edge where req[owner]=0. At that point ptr <= owner+1.
  - Reset forces ARB.
- Undefined: no lock port, no LOCKED state, pure round-robin.

Decomposition:
- Package ff_share_pkg holds:
  - the FSM state encoding (ARB=0, LOCKED=1);
  - the rr-first-set helper function;
  - default width constants.
- One sub-module, rr_pick: combinational. Takes req, ptr and enable; produces the one-hot grant and the binary index. It is instantiated once.
- The shared register is the team's library N-bit register with the load mux placed in front of it.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> gnt=0, q=0, q_valid=0, q_tag=0. After release, the first grant is gnt=4'b0001.
- Fair rotation: req=4'b1111, q_ready=1, data slices 8'h10/8'h21/8'h32/8'h43 -> q sequence 10,21,32,43,10 with q_tag 0,1,2,3,0 on consecutive cycles.
- Skip and wrap: ptr=3, req=4'b0101 -> grant index 0, then index 2, then index 0; ptr wraps 3->1->3->1.
- Backpressure: q_valid=1 with q_ready=0 for 4 cycles while req=4'b0010 -> gnt=0, q stable. When q_ready rises, the drain and the requester-1 load happen at the same edge.
- Idle drain: req=0, q_ready=1 -> q_valid drops after one cycle, ptr unchanged.
- Lock (with FF_SHARE_ARB_LOCK_EN): req=4'b0011, lock=4'b0001 for 3 grants -> q_tag 0,0,0 while requester 1 is starved. Then lock[0]=0 -> next two grants are tag 0 then tag 1.
